// File: rtl/pri_decode_24_hold.sv
// ============================================================================
// pri_decode_24_hold: handshaked 2-to-4 decoder; holds one-hot I, then idles.
// Optional build macro: PRI_DEC_STALL_CNT_EN (adds stall_cnt output).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pri_decode_24_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Y,
  input  logic       V,
  output logic       rdy,
  output logic [3:0] I,
  output logic       i_valid
`ifdef PRI_DEC_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
    $error("pri_decode_24_hold: HOLD_CYCLES out of range");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_gap
    $error("pri_decode_24_hold: GAP_CYCLES out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       i_q, i_d;
  logic             i_valid_q, i_valid_d;

  assign rdy     = (state_q == IDLE);
  assign I       = i_q;
  assign i_valid = i_valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    i_valid_d = i_valid_q;
    case (state_q)
      IDLE: begin
        if (V) begin
          state_d   = HOLD;
          cnt_d     = HOLD_LOAD;
          i_d       = 4'b0001 << Y;
          i_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          i_d       = 4'b0000;
          i_valid_d = 1'b0;
          // With no gap the decoder returns straight to IDLE.
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        i_d       = 4'b0000;
        i_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_q       <= 4'b0000;
      i_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      i_valid_q <= i_valid_d;
    end
  end

`ifdef PRI_DEC_STALL_CNT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where the source is backpressured; saturates at 8'hFF.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (V && !rdy && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 8'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pri_decode_24_hold.sv
// ============================================================================
// tb_pri_decode_24_hold: directed checks of pri_decode_24_hold (4/1 and 1/0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pri_decode_24_hold;

  logic       clk;
  logic       rst_n;
  logic [1:0] Y, Y2;
  logic       V, V2;
  logic       rdy, rdy2;
  logic [3:0] I, I2;
  logic       i_valid, i_valid2;
`ifdef PRI_DEC_STALL_CNT_EN
  logic [7:0] stall_cnt, stall_cnt2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pri_decode_24_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Y(Y), .V(V),
    .rdy(rdy), .I(I), .i_valid(i_valid)
`ifdef PRI_DEC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pri_decode_24_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .Y(Y2), .V(V2),
    .rdy(rdy2), .I(I2), .i_valid(i_valid2)
`ifdef PRI_DEC_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] ei, input logic ev, input logic er);
    chk({tag, " I"}, {4'd0, I}, {4'd0, ei});
    chk({tag, " i_valid"}, {7'd0, i_valid}, {7'd0, ev});
    chk({tag, " rdy"}, {7'd0, rdy}, {7'd0, er});
  endtask

  initial begin
    rst_n = 1'b0;
    Y = 2'd0; V = 1'b0;
    Y2 = 2'd0; V2 = 1'b0;

    // Reset held for three cycles, then released.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a("reset", 4'b0000, 1'b0, 1'b1);
    end
    chk("reset dut2 rdy", {7'd0, rdy2}, 8'd1);
    rst_n = 1'b1;
    tick();
    chk_a("post-reset idle", 4'b0000, 1'b0, 1'b1);
`ifdef PRI_DEC_STALL_CNT_EN
    chk("reset stall_cnt", stall_cnt, 8'd0);
`endif

    // Single decode of Y=2.
    Y = 2'd2; V = 1'b1;
    tick();
    chk_a("single hold1", 4'b0100, 1'b1, 1'b0);
    V = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_a("single hold", 4'b0100, 1'b1, 1'b0);
    end
    tick();
    chk_a("single gap", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_a("single idle", 4'b0000, 1'b0, 1'b1);

    // All codes back-to-back with V held high; Y changes during hold are ignored.
    V = 1'b1; Y = 2'd0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] exp_i;
      exp_i = 4'b0001 << k;
      tick();
      chk_a("b2b hold1", exp_i, 1'b1, 1'b0);
      Y = 2'(k + 1);
      for (int c = 2; c <= 4; c++) begin
        tick();
        chk_a("b2b hold", exp_i, 1'b1, 1'b0);
      end
      tick();
      chk_a("b2b gap", 4'b0000, 1'b0, 1'b0);
      if (k == 3) V = 1'b0;
      tick();
      chk_a("b2b idle", 4'b0000, 1'b0, 1'b1);
    end

    // Backpressure: Y=1 accepted, Y=3 presented while busy.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    Y = 2'd1; V = 1'b1;
    tick();
    chk_a("bp hold1", 4'b0010, 1'b1, 1'b0);
    Y = 2'd3;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_a("bp hold", 4'b0010, 1'b1, 1'b0);
    end
    tick();
    chk_a("bp gap", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_a("bp idle", 4'b0000, 1'b0, 1'b1);
`ifdef PRI_DEC_STALL_CNT_EN
    chk("bp stall_cnt", stall_cnt, 8'd5);
`endif
    tick();
    chk_a("bp accept3", 4'b1000, 1'b1, 1'b0);
`ifdef PRI_DEC_STALL_CNT_EN
    chk("bp stall_cnt hold", stall_cnt, 8'd5);
`endif
    V = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk_a("bp drained", 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset in the second hold cycle of Y=0.
    Y = 2'd0; V = 1'b1;
    tick();
    chk_a("mid hold1", 4'b0001, 1'b1, 1'b0);
    V = 1'b0;
    tick();
    chk_a("mid hold2", 4'b0001, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async reset", 4'b0000, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("after reset", 4'b0000, 1'b0, 1'b1);
    Y = 2'd3; V = 1'b1;
    tick();
    chk_a("reaccept3", 4'b1000, 1'b1, 1'b0);
    V = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk_a("reaccept drained", 4'b0000, 1'b0, 1'b1);

    // HOLD=1, GAP=0 instance: continuous V, Y alternating 0/3.
    V2 = 1'b1; Y2 = 2'd0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("g0 I code0", {4'd0, I2}, 8'h01);
      chk("g0 rdy busy", {7'd0, rdy2}, 8'd0);
      Y2 = 2'd3;
      tick();
      chk("g0 I zero", {4'd0, I2}, 8'h00);
      chk("g0 rdy idle", {7'd0, rdy2}, 8'd1);
      tick();
      chk("g0 I code3", {4'd0, I2}, 8'h08);
      chk("g0 i_valid", {7'd0, i_valid2}, 8'd1);
      Y2 = 2'd0;
      tick();
      chk("g0 I zero2", {4'd0, I2}, 8'h00);
    end
    V2 = 1'b0;
    tick();
    tick();
    chk("g0 final idle", {7'd0, rdy2}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pri_decode_24_hold.md
Name: pri_decode_24_hold

Overview:
- Sequential 2-to-4 decoder: the receive-side counterpart of the 4-to-2 priority encoder.
- Accepts an encoded index Y[1:0] qualified by V through a valid/ready handshake.
- Regenerates the one-hot request line I[3:0], held for a programmable number of cycles, then a programmable idle gap.
- Sits downstream of an encoder/arbiter link, re-expanding the compressed grant into per-requester strobes.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output is held; legal range 1..2^CNT_W-1.
- GAP_CYCLES, 1, cycles of all-zero output after each hold before the next accept; legal range 0..2^CNT_W-1.
- CNT_W, 8, width of the internal hold/gap down-counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- Y  input  2  encoded index, 0..3.
- V  input  1  index valid; Y is meaningful only while V=1.
- rdy  output  1  decoder can accept; combinational, equals (state==IDLE).
- I  output  4  one-hot decoded output, registered.
- i_valid  output  1  high exactly while I is non-zero (HOLD state), registered.

Behaviour:
- Reset (async, rst_n=0):
  - I=4'b0000, i_valid=0, counter=0, state=IDLE, so rdy=1.
  - Takes effect immediately, including mid-HOLD or mid-GAP.
  - Release is sampled on the next rising edge.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - rdy=1, I=0.
  - Accept occurs on a rising edge with V=1 and rdy=1: latch Y, load counter=HOLD_CYCLES-1, go to HOLD.
  - The I/i_valid registers update on the same edge, giving I = 4'b0001<<Y and i_valid=1 from the cycle after the accept edge (latency 1).
- HOLD:
  - rdy=0; I and i_valid are held stable.
  - Counter decrements each edge.
  - On the edge where counter==0, I and i_valid clear. Next state is GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0, else IDLE.
  - I is therefore non-zero for exactly HOLD_CYCLES cycles.
- GAP:
  - rdy=0, I=0.
  - Counter decrements; on the edge where counter==0, go to IDLE. Gap lasts exactly GAP_CYCLES cycles.
- Throughput: one accepted code per HOLD_CYCLES+GAP_CYCLES+1 cycles when V is held high continuously.
- Handshake rules:
  - V=1 while rdy=0 is not captured and is not queued.
  - The source holds Y/V until it sees rdy=1 at a rising edge.
  - Changes to Y while rdy=0 have no effect on I.
- V=0 in IDLE: stay in IDLE; Y is ignored.
- Y is 2 bits, so every code is legal and I is always one-hot or zero, never multi-hot.
- Counter is never reloaded except on accept or on the HOLD→GAP transition. No wrap-around occurs within the legal parameter range.
- Out-of-range parameters (HOLD_CYCLES=0 or >2^CNT_W-1) are unsupported; the implementation flags them with an elaboration-time error.

Optional Feature:
- Macro PRI_DEC_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt [7:0].
  - 8-bit saturating count of cycles with V=1 and rdy=0 (source backpressured).
  - Saturates at 8'hFF; cleared only by rst_n; reset value 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset/idle: assert rst_n=0 for 3 cycles, V=0 -> I=0000, i_valid=0, rdy=1 throughout. Then release; still idle.
- Single decode, defaults (HOLD=4, GAP=1): Y=2'b10, V=1 for one accept edge -> I=0100 and i_valid=1 for exactly 4 cycles starting 1 cycle after the accept. Then 1 cycle of I=0000 with rdy=0, then rdy=1.
- All codes back-to-back, V held high with Y stepping 0,1,2,3 on each accept -> I sequence 0001,0010,0100,1000. Each held 4 cycles; accepts spaced 6 cycles apart.
- Backpressure: during HOLD of Y=1, change Y to 3 with V=1 -> I stays 0010 until hold ends. Y=3 is accepted only at the next IDLE edge. With PRI_DEC_STALL_CNT_EN defined, stall_cnt increments once per blocked cycle (5 for this case).
- Reset mid-operation: assert rst_n=0 asynchronously in the 2nd HOLD cycle of Y=0 -> I=0000, i_valid=0 immediately (before next edge), rdy=1. After release, a new accept of Y=3 gives I=1000.
- GAP_CYCLES=0, HOLD_CYCLES=1 build: continuous V=1, Y alternating 0/3 -> I alternates 0001, 0000, 1000, 0000, i.e. one accept every 2 cycles.
